sprite_write_dispatcher: RTL and testbench
==========================================

# sprite_write_dispatcher

Downstream stage of the sprite data-word generator. It consumes the registered 32-bit sprite word: [31:29] sprite enable/ID, [28:19] x, [18:9] y, [8:0] offset. It forwards that word to the graphics processor's instruction input as a single register-write (WBR) instruction, at most once per video frame and only when the word has changed. Changes are coalesced, so the processor always receives the most recent position. The block respects the processor's FIFO-full back-pressure.

## Interface
- SPRITE_REG, default 5'd1: target sprite register index, placed in dataA[8:4].
- OPCODE_WBR, default 4'b0000: write-register opcode, placed in dataA[3:0].
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset (one clock; reset is synchronous and active-high).
- data_b_in  input  32  sprite word from the generator stage; may change on any cycle.
- frame_tick  input  1  one-cycle pulse at start of vertical blank.
- fifo_full  input  1  graphics-processor instruction FIFO full; no write is issued while high.
- dataA  output  32  instruction word: {23'd0, SPRITE_REG, OPCODE_WBR}; constant, including during reset.
- dataB  output  32  data word of the write; registered.
- wrreg  output  1  write strobe; high exactly one cycle per write.
- pending  output  1  captured word differs from last word sent.
- write_count  output  16  number of writes issued; wraps.

## Operation
- shadow register: shadow <= data_b_in every cycle.
- last_sent register: updated only when a write is issued.
- pending is combinational from registers: pending = (shadow != last_sent).
- FSM states:
  - IDLE: if pending && frame_tick, go to SEND. Otherwise stay. A frame_tick with pending low is discarded.
  - SEND: if !fifo_full, do wrreg<=1, dataB<=shadow, last_sent<=shadow, write_count<=write_count+1, and go to HOLD. If fifo_full, stay in SEND and wait indefinitely with wrreg low.
  - HOLD: wrreg<=0, go to IDLE. This gives a mandatory one-cycle low gap between strobes.
- frame_tick in SEND or HOLD is ignored. It is not queued.
- Coalescing: any number of data_b_in changes between ticks produce one write, carrying the shadow value in the firing cycle.
- A change in the same cycle a write fires:
  - The old shadow is sent.
  - The new value lands in shadow on the next edge.
  - pending reasserts, and the new value is sent on a later tick.
- A data_b_in change back to last_sent before a tick clears pending. No write results.
- write_count is a 16-bit unsigned counter: 16'hFFFF + 1 = 16'h0000.
- Reset values:
  - State: IDLE.
  - shadow = 0, last_sent = 0, dataB = 0, wrreg = 0, write_count = 0.
  - pending = 0. Consequently any nonzero data_b_in after reset produces a write on the first tick.

## Timing
- data_b_in change in cycle m: shadow is updated in cycle m+1, and pending is high in m+1 (if it differs from last_sent).
- frame_tick in cycle n with pending high, state IDLE, and fifo_full low in n+1: wrreg is high in cycle n+2 with dataB valid. Latency is 2 cycles.
- write_count and last_sent change on the same edge wrreg rises; pending drops in n+2.
- fifo_full high for k cycles from n+1: wrreg rises in cycle n+2+k.
- Minimum spacing between strobes is 3 cycles, and in practice one per frame_tick.
- Reset asserted in any state: at the next edge the FSM is in IDLE and wrreg is 0. A write already in SEND is abandoned, not completed.
- dataB holds its last written value until the next write. It does not follow data_b_in.

## Test plan
- Reset then data_b_in=32'h2028_0000 (enable 001, x=5, y=0), tick at cycle 10: wrreg high in cycle 12 only, dataB=32'h2028_0000, write_count=1, pending=0 in cycle 12.
- Three changes between ticks (x=5, 6, 7), then a tick: exactly one write, dataB holds x=7 (dataB[28:19]=7), write_count increments by 1.
- Tick with data_b_in equal to last sent: no wrreg, pending stays 0. Change A->B->A before a tick: no write.
- fifo_full held high for 5 cycles across a pending tick at cycle n: wrreg in cycle n+7, once; a second tick during the wait is ignored.
- data_b_in changes in the strobe-firing cycle: old value is written, pending is high 1 cycle later, and the next tick writes the new value.
- Reset asserted while in SEND (fifo_full high): wrreg never pulses, write_count=0. Also preload to 16'hFFFF and check one write gives 16'h0000.

Source files
------------

// File: rtl/sprite_write_dispatcher_if.sv
// Bus between the sprite word generator / graphics processor and the
// sprite write dispatcher. The master drives the sprite word and flow control.
interface sprite_write_dispatcher_if;
    logic [31:0] data_b_in;
    logic        frame_tick;
    logic        fifo_full;
    logic [31:0] dataA;
    logic [31:0] dataB;
    logic        wrreg;
    logic        pending;
    logic [15:0] write_count;

    modport master (
        output data_b_in, frame_tick, fifo_full,
        input  dataA, dataB, wrreg, pending, write_count
    );

    modport slave (
        input  data_b_in, frame_tick, fifo_full,
        output dataA, dataB, wrreg, pending, write_count
    );
endinterface

// File: rtl/sprite_write_dispatcher.sv
// Forwards the latest sprite word to the graphics processor as one WBR
// register write per frame, only when the word changed since the last write.
module sprite_write_dispatcher #(
    parameter logic [4:0] SPRITE_REG = 5'd1,
    parameter logic [3:0] OPCODE_WBR = 4'b0000
) (
    input  logic                      clk,
    input  logic                      reset,
    sprite_write_dispatcher_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        HOLD
    } state_t;

    state_t      state;
    logic [31:0] shadow;
    logic [31:0] last_sent;
    logic [31:0] data_b;
    logic        wrreg_q;
    logic [15:0] count_q;

    assign bus.dataA       = {23'd0, SPRITE_REG, OPCODE_WBR};
    assign bus.dataB       = data_b;
    assign bus.wrreg       = wrreg_q;
    assign bus.write_count = count_q;
    assign bus.pending     = (shadow != last_sent);

    // NOTE: every register here is state, so all use non-blocking assignments
    // and all take the synchronous reset, including the data-path registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            shadow    <= 32'd0;
            last_sent <= 32'd0;
            data_b    <= 32'd0;
            wrreg_q   <= 1'b0;
            count_q   <= 16'd0;
        end else begin
            shadow <= bus.data_b_in;
            case (state)
                IDLE: begin
                    wrreg_q <= 1'b0;
                    if (bus.pending && bus.frame_tick) begin
                        state <= SEND;
                    end
                end
                SEND: begin
                    // The word sent is whatever shadow holds in the firing cycle.
                    if (!bus.fifo_full) begin
                        wrreg_q   <= 1'b1;
                        data_b    <= shadow;
                        last_sent <= shadow;
                        count_q   <= count_q + 16'd1;
                        state     <= HOLD;
                    end else begin
                        wrreg_q <= 1'b0;
                    end
                end
                HOLD: begin
                    wrreg_q <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    wrreg_q <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_write_dispatcher.sv
// Self-checking bench for sprite_write_dispatcher: directed scenarios plus a
// randomized run checked against a transaction-level reference model.
module tb_sprite_write_dispatcher;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    sprite_write_dispatcher_if bus ();

    sprite_write_dispatcher dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [31:0] DATA_A_EXP = 32'h0000_0010;

    // Reference model: a write request is accepted on a tick when the captured
    // word differs from the last one sent and no request or strobe is in flight;
    // the request completes on the first cycle the FIFO is not full.
    logic [31:0] m_shadow = '0, m_last = '0, m_datab = '0;
    logic [15:0] m_cnt = '0;
    logic        m_wr = 1'b0, m_req = 1'b0;

    always @(posedge clk) begin
        logic busy, pend;
        if (reset) begin
            m_shadow = '0; m_last = '0; m_datab = '0; m_cnt = '0;
            m_wr = 1'b0; m_req = 1'b0;
        end else begin
            busy = m_req || m_wr;
            pend = (m_shadow != m_last);
            if (m_req && !bus.fifo_full) begin
                m_datab = m_shadow;
                m_last  = m_shadow;
                m_cnt   = m_cnt + 16'd1;
                m_wr    = 1'b1;
                m_req   = 1'b0;
            end else begin
                m_wr = 1'b0;
            end
            if (!busy && bus.frame_tick && pend) m_req = 1'b1;
            m_shadow = bus.data_b_in;
        end
    end

    function automatic logic [31:0] mk(input logic [2:0] en, input logic [9:0] x,
                                       input logic [9:0] y, input logic [8:0] off);
        return {en, x, y, off};
    endfunction

    // Drive one cycle of inputs, then return at the next falling edge.
    task automatic step(input logic [31:0] d, input logic t, input logic f);
        bus.data_b_in  = d;
        bus.frame_tick = t;
        bus.fifo_full  = f;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(32'd0, 1'b0, 1'b0);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (bus.wrreg !== 1'b0) begin n_bad++; $display("FAIL reset_wrreg: got %b want 0", bus.wrreg); end
        n_cmp++; if (bus.dataB !== 32'd0) begin n_bad++; $display("FAIL reset_dataB: got %h want 0", bus.dataB); end
        n_cmp++; if (bus.write_count !== 16'd0) begin n_bad++; $display("FAIL reset_count: got %h want 0", bus.write_count); end
        n_cmp++; if (bus.pending !== 1'b0) begin n_bad++; $display("FAIL reset_pending: got %b want 0", bus.pending); end
        n_cmp++; if (bus.dataA !== DATA_A_EXP) begin n_bad++; $display("FAIL reset_dataA: got %h want %h", bus.dataA, DATA_A_EXP); end
    endtask

    task automatic test_first_write();
        logic [31:0] d = 32'h2028_0000;
        logic seen;
        do_reset();
        for (int i = 0; i < 9; i++) step(d, 1'b0, 1'b0);
        n_cmp++; if (bus.pending !== 1'b1) begin n_bad++; $display("FAIL first_pending_before: got %b want 1", bus.pending); end
        step(d, 1'b1, 1'b0);
        n_cmp++; if (bus.wrreg !== 1'b0) begin n_bad++; $display("FAIL first_wrreg_n1: got %b want 0", bus.wrreg); end
        step(d, 1'b0, 1'b0);
        n_cmp++; if (bus.wrreg !== 1'b1) begin n_bad++; $display("FAIL first_wrreg_n2: got %b want 1", bus.wrreg); end
        n_cmp++; if (bus.dataB !== d) begin n_bad++; $display("FAIL first_dataB: got %h want %h", bus.dataB, d); end
        n_cmp++; if (bus.write_count !== 16'd1) begin n_bad++; $display("FAIL first_count: got %h want 1", bus.write_count); end
        n_cmp++; if (bus.pending !== 1'b0) begin n_bad++; $display("FAIL first_pending_after: got %b want 0", bus.pending); end
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin step(d, 1'b0, 1'b0); seen |= bus.wrreg; end
        n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL first_single_strobe: got extra strobe %b want 0", seen); end
    endtask

    task automatic test_coalesce();
        logic [31:0] d7 = mk(3'd1, 10'd7, 10'd3, 9'd9);
        logic seen;
        do_reset();
        step(mk(3'd1, 10'd5, 10'd3, 9'd9), 1'b0, 1'b0);
        step(mk(3'd1, 10'd6, 10'd3, 9'd9), 1'b0, 1'b0);
        step(d7, 1'b0, 1'b0);
        step(d7, 1'b1, 1'b0);
        step(d7, 1'b0, 1'b0);
        n_cmp++; if (bus.wrreg !== 1'b1) begin n_bad++; $display("FAIL coalesce_wrreg: got %b want 1", bus.wrreg); end
        n_cmp++; if (bus.dataB[28:19] !== 10'd7) begin n_bad++; $display("FAIL coalesce_x: got %0d want 7", bus.dataB[28:19]); end
        n_cmp++; if (bus.dataB !== d7) begin n_bad++; $display("FAIL coalesce_dataB: got %h want %h", bus.dataB, d7); end
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin step(d7, 1'b0, 1'b0); seen |= bus.wrreg; end
        n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL coalesce_extra: got strobe %b want 0", seen); end
        n_cmp++; if (bus.write_count !== 16'd1) begin n_bad++; $display("FAIL coalesce_count: got %h want 1", bus.write_count); end
    endtask

    task automatic test_no_change();
        logic [31:0] a = mk(3'd2, 10'd100, 10'd50, 9'd1);
        logic [31:0] b = mk(3'd2, 10'd101, 10'd50, 9'd1);
        logic seen, pend_seen;
        do_reset();
        step(a, 1'b0, 1'b0);
        step(a, 1'b1, 1'b0);
        step(a, 1'b0, 1'b0);
        step(a, 1'b0, 1'b0);
        step(a, 1'b0, 1'b0);
        step(a, 1'b1, 1'b0);
        seen = 1'b0; pend_seen = 1'b0;
        for (int i = 0; i < 4; i++) begin step(a, 1'b0, 1'b0); seen |= bus.wrreg; pend_seen |= bus.pending; end
        n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL same_word_strobe: got %b want 0", seen); end
        n_cmp++; if (pend_seen !== 1'b0) begin n_bad++; $display("FAIL same_word_pending: got %b want 0", pend_seen); end
        step(b, 1'b0, 1'b0);
        n_cmp++; if (bus.pending !== 1'b1) begin n_bad++; $display("FAIL aba_pending_b: got %b want 1", bus.pending); end
        step(a, 1'b0, 1'b0);
        n_cmp++; if (bus.pending !== 1'b0) begin n_bad++; $display("FAIL aba_pending_a: got %b want 0", bus.pending); end
        step(a, 1'b1, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin step(a, 1'b0, 1'b0); seen |= bus.wrreg; end
        n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL aba_strobe: got %b want 0", seen); end
        n_cmp++; if (bus.write_count !== 16'd1) begin n_bad++; $display("FAIL aba_count: got %h want 1", bus.write_count); end
    endtask

    task automatic test_backpressure();
        logic [31:0] d = mk(3'd3, 10'd200, 10'd20, 9'd33);
        logic [31:0] f = mk(3'd3, 10'd201, 10'd21, 9'd33);
        logic seen;
        do_reset();
        step(d, 1'b0, 1'b0);
        step(d, 1'b1, 1'b0);
        seen = 1'b0;
        for (int i = 1; i <= 5; i++) begin step(d, (i == 3), 1'b1); seen |= bus.wrreg; end
        n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL bp_early_strobe: got %b want 0", seen); end
        step(d, 1'b0, 1'b0);
        n_cmp++; if (bus.wrreg !== 1'b1) begin n_bad++; $display("FAIL bp_wrreg_n7: got %b want 1", bus.wrreg); end
        n_cmp++; if (bus.dataB !== d) begin n_bad++; $display("FAIL bp_dataB: got %h want %h", bus.dataB, d); end
        step(f, 1'b0, 1'b0);
        n_cmp++; if (bus.wrreg !== 1'b0) begin n_bad++; $display("FAIL bp_gap: got %b want 0", bus.wrreg); end
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin step(f, 1'b0, 1'b0); seen |= bus.wrreg; end
        n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL bp_tick_queued: got strobe %b want 0", seen); end
        n_cmp++; if (bus.pending !== 1'b1) begin n_bad++; $display("FAIL bp_pending_new: got %b want 1", bus.pending); end
        n_cmp++; if (bus.write_count !== 16'd1) begin n_bad++; $display("FAIL bp_count: got %h want 1", bus.write_count); end
    endtask

    task automatic test_change_on_fire();
        logic [31:0] g = mk(3'd4, 10'd10, 10'd11, 9'd12);
        logic [31:0] h = mk(3'd4, 10'd13, 10'd14, 9'd15);
        do_reset();
        step(g, 1'b0, 1'b0);
        step(g, 1'b1, 1'b0);
        step(h, 1'b0, 1'b0);
        n_cmp++; if (bus.wrreg !== 1'b1) begin n_bad++; $display("FAIL fire_wrreg: got %b want 1", bus.wrreg); end
        n_cmp++; if (bus.dataB !== g) begin n_bad++; $display("FAIL fire_old_value: got %h want %h", bus.dataB, g); end
        n_cmp++; if (bus.pending !== 1'b1) begin n_bad++; $display("FAIL fire_pending: got %b want 1", bus.pending); end
        step(h, 1'b0, 1'b0);
        n_cmp++; if (bus.dataB !== g) begin n_bad++; $display("FAIL fire_dataB_hold: got %h want %h", bus.dataB, g); end
        step(h, 1'b1, 1'b0);
        step(h, 1'b0, 1'b0);
        n_cmp++; if (bus.wrreg !== 1'b1) begin n_bad++; $display("FAIL fire_second_wrreg: got %b want 1", bus.wrreg); end
        n_cmp++; if (bus.dataB !== h) begin n_bad++; $display("FAIL fire_new_value: got %h want %h", bus.dataB, h); end
        n_cmp++; if (bus.write_count !== 16'd2) begin n_bad++; $display("FAIL fire_count: got %h want 2", bus.write_count); end
    endtask

    task automatic test_reset_in_send();
        logic [31:0] d = mk(3'd5, 10'd300, 10'd301, 9'd302);
        logic seen;
        do_reset();
        step(d, 1'b0, 1'b0);
        step(d, 1'b1, 1'b1);
        step(d, 1'b0, 1'b1);
        step(d, 1'b0, 1'b1);
        reset = 1'b1;
        step(d, 1'b0, 1'b1);
        reset = 1'b0;
        n_cmp++; if (bus.wrreg !== 1'b0) begin n_bad++; $display("FAIL rst_send_wrreg: got %b want 0", bus.wrreg); end
        n_cmp++; if (bus.pending !== 1'b0) begin n_bad++; $display("FAIL rst_send_pending: got %b want 0", bus.pending); end
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin step(d, 1'b0, 1'b0); seen |= bus.wrreg; end
        n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL rst_send_abandon: got strobe %b want 0", seen); end
        n_cmp++; if (bus.write_count !== 16'd0) begin n_bad++; $display("FAIL rst_send_count: got %h want 0", bus.write_count); end
        n_cmp++; if (bus.dataB !== 32'd0) begin n_bad++; $display("FAIL rst_send_dataB: got %h want 0", bus.dataB); end
    endtask

    task automatic test_wrap();
        logic [31:0] d = mk(3'd6, 10'd1, 10'd2, 9'd3);
        do_reset();
        force dut.count_q = 16'hFFFF;
        m_cnt = 16'hFFFF;
        step(32'd0, 1'b0, 1'b0);
        release dut.count_q;
        step(32'd0, 1'b0, 1'b0);
        n_cmp++; if (bus.write_count !== 16'hFFFF) begin n_bad++; $display("FAIL wrap_preload: got %h want ffff", bus.write_count); end
        step(d, 1'b0, 1'b0);
        step(d, 1'b1, 1'b0);
        step(d, 1'b0, 1'b0);
        n_cmp++; if (bus.wrreg !== 1'b1) begin n_bad++; $display("FAIL wrap_wrreg: got %b want 1", bus.wrreg); end
        n_cmp++; if (bus.write_count !== 16'h0000) begin n_bad++; $display("FAIL wrap_count: got %h want 0000", bus.write_count); end
    endtask

    task automatic test_random();
        logic [31:0] pool [4];
        logic [31:0] d;
        logic t, f;
        pool[0] = mk(3'd1, 10'd5, 10'd0, 9'd0);
        pool[1] = mk(3'd1, 10'd6, 10'd0, 9'd0);
        pool[2] = mk(3'd7, 10'd1023, 10'd1023, 9'd511);
        pool[3] = 32'd0;
        do_reset();
        d = pool[0];
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 9) < 3) d = pool[$urandom_range(0, 3)];
            t = ($urandom_range(0, 5) == 0);
            f = ($urandom_range(0, 3) == 0);
            reset = ($urandom_range(0, 199) == 0);
            step(d, t, f);
            n_cmp++; if (bus.wrreg !== m_wr) begin n_bad++; $display("FAIL rand_wrreg c=%0d: got %b want %b", c, bus.wrreg, m_wr); end
            n_cmp++; if (bus.dataB !== m_datab) begin n_bad++; $display("FAIL rand_dataB c=%0d: got %h want %h", c, bus.dataB, m_datab); end
            n_cmp++; if (bus.pending !== (m_shadow != m_last)) begin n_bad++; $display("FAIL rand_pending c=%0d: got %b want %b", c, bus.pending, (m_shadow != m_last)); end
            n_cmp++; if (bus.write_count !== m_cnt) begin n_bad++; $display("FAIL rand_count c=%0d: got %h want %h", c, bus.write_count, m_cnt); end
            n_cmp++; if (bus.dataA !== DATA_A_EXP) begin n_bad++; $display("FAIL rand_dataA c=%0d: got %h want %h", c, bus.dataA, DATA_A_EXP); end
        end
        reset = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.data_b_in  = 32'd0;
        bus.frame_tick = 1'b0;
        bus.fifo_full  = 1'b0;
        @(negedge clk);
        test_reset();
        test_first_write();
        test_coalesce();
        test_no_change();
        test_backpressure();
        test_change_on_fire();
        test_reset_in_send();
        test_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
